// File: rtl/port_merge_fifo.sv
// port_merge_fifo: round-robin N-to-1 stream merger into a FIFO tagged with source channel
module port_merge_fifo #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH = 4,
  localparam int ID_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          count
);
  localparam int PTR_W = CNT_W - 1;
  logic [ID_W+WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ID_W-1:0] rr_ptr, g;
  logic [2*CHANNELS-1:0] rot;
  logic [ID_W:0] sum;
  logic found, push, pop;
  always_comb begin
    rot = {in_valid, in_valid} >> rr_ptr;
    g = '0;
    sum = '0;
    found = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (rot[k]) begin
        sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        g = ID_W'(sum >= (ID_W+1)'(CHANNELS) ? sum - (ID_W+1)'(CHANNELS) : sum);
        found = 1'b1;
      end
  end
  assign push = found && count != CNT_W'(DEPTH) && !rst;
  assign pop = out_valid && out_ready;
  assign in_ready = push ? CHANNELS'(1) << g : '0;
  assign out_valid = count != '0;
  assign {out_id, out_data} = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {g, in_data[g*WIDTH +: WIDTH]};
        wr_ptr <= wr_ptr + PTR_W'(1);
        rr_ptr <= g == ID_W'(CHANNELS - 1) ? '0 : g + ID_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      assert ($onehot0(in_ready));
      assert (count <= CNT_W'(DEPTH));
      assert (!(pop && count == '0));
    end
endmodule

// File: tb/tb_port_merge_fifo.sv
// tb_port_merge_fifo: directed self-checking bench for port_merge_fifo
module tb_port_merge_fifo;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] in_valid;
  logic [127:0] in_data;
  logic [3:0] in_ready;
  logic out_valid;
  logic [31:0] out_data;
  logic [1:0] out_id;
  logic out_ready;
  logic [2:0] count;
  int tests = 0;
  int fails = 0;
  port_merge_fifo dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
    .out_ready(out_ready),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_data"}, 64'(out_data), 64'(0));
    chk({tag, "_id"}, 64'(out_id), 64'(0));
    chk({tag, "_ready"}, 64'(in_ready), 64'(0));
  endtask
  task automatic chk_head(input string tag, input logic [1:0] id, input logic [31:0] data, input logic [2:0] cnt);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_id"}, 64'(out_id), 64'(id));
    chk({tag, "_data"}, 64'(out_data), 64'(data));
    chk({tag, "_count"}, 64'(count), 64'(cnt));
  endtask
  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    chk_empty("rst1");
    tick();
    chk_empty("rst2");
    rst = 1'b0;
    tick();
    chk_empty("idle");
    in_valid = 4'b0100;
    in_data[64 +: 32] = 32'h0000_002A;
    #1;
    chk("single_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    in_valid = '0;
    #1;
    chk_head("single", 2'd2, 32'd42, 3'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk_empty("single_pop");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'(k);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 64'(in_ready), 64'(4'b0001 << k));
      tick();
    end
    chk("full_count", 64'(count), 64'(4));
    chk("full_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    chk("full_ready_pop", 64'(in_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("drain%0d", k), 2'(k), 32'(k), 3'(4 - k));
      tick();
      in_valid = '0;
      #1;
    end
    chk_empty("drained");
    out_ready = 1'b0;
    in_data = '0;
    in_data[32 +: 32] = 32'hA1;
    in_data[96 +: 32] = 32'hB3;
    in_data[0 +: 32] = 32'hC0;
    in_valid = 4'b0010;
    #1;
    chk("push_a", 64'(in_ready), 64'(4'b0010));
    tick();
    in_valid = 4'b1000;
    #1;
    chk("push_b", 64'(in_ready), 64'(4'b1000));
    tick();
    in_valid = 4'b0001;
    #1;
    chk("push_c", 64'(in_ready), 64'(4'b0001));
    tick();
    in_valid = '0;
    #1;
    chk_head("three", 2'd1, 32'hA1, 3'd3);
    tick();
    chk_head("hold", 2'd1, 32'hA1, 3'd3);
    out_ready = 1'b1;
    tick();
    chk_head("pop_a", 2'd3, 32'hB3, 3'd2);
    in_data[32 +: 32] = 32'hD1;
    in_valid = 4'b0010;
    #1;
    chk("simul_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    in_valid = '0;
    #1;
    chk_head("simul", 2'd0, 32'hC0, 3'd2);
    tick();
    chk_head("wrap", 2'd1, 32'hD1, 3'd1);
    tick();
    chk_empty("wrap_done");
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'h50 + 32'(k);
    #1;
    chk("mid_grant_first", 64'(in_ready), 64'(4'b0100));
    tick();
    tick();
    tick();
    chk("mid_count", 64'(count), 64'(3));
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("mid_count0", 64'(count), 64'(0));
    chk("mid_valid0", 64'(out_valid), 64'(0));
    chk("mid_grant0", 64'(in_ready), 64'(4'b0001));
    tick();
    in_valid = '0;
    #1;
    chk_head("mid_after", 2'd0, 32'h50, 3'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
